pcileech_cfgspace_arbiter: RTL
==============================

PCILEECH_CFGSPACE_ARBITER -- requirements
Module: pcileech_cfgspace_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8, meaning the number of wait cycles after which a pending request is force-granted (range 1..15).
REQ-002 SHALL have port clk_pcie  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port tlp_valid  in  1  PCIe cfg request present.
REQ-005 SHALL have port tlp_ready  out  1  TLP holding slot empty.
REQ-006 SHALL have port tlp_req  in  71  {wr, addr[9:0], be[3:0], data[31:0], tag[7:0], reqid[15:0]}.
REQ-007 SHALL have port tlp_wren_en  in  1  1 = TLP writes modify the shadow; 0 = TLP write byte enables are forced to 0.
REQ-008 SHALL have port usb_valid  in  1  USB request present.
REQ-009 SHALL have port usb_ready  out  1  USB holding slot empty.
REQ-010 SHALL have port usb_req  in  48  {wr, addr_lo, addr[9:0], be[3:0], data[31:0]}.
REQ-011 SHALL have port int_valid  in  1  internal request present.
REQ-012 SHALL have port int_ready  out  1  INT holding slot empty.
REQ-013 SHALL have port int_req  in  47  {wr, addr[9:0], be[3:0], data[31:0]}.
REQ-014 SHALL have port bram_addr  out  10  DWORD address to the BRAM wrapper.
REQ-015 SHALL have port bram_be  out  4  write byte enables.
REQ-016 SHALL have port bram_data  out  32  write data.
REQ-017 SHALL have port bram_tag  out  8  read tag.
REQ-018 SHALL have port bram_tp  out  2  source: 00 idle, 01 TLP, 10 USB, 11 INT.
REQ-019 SHALL have port bram_reqid  out  16  requester ID.
REQ-020 SHALL have port bram_tlpwr  out  1  issued op is a TLP write (completion without data).
REQ-021 SHALL have port busy  out  1  any slot occupied or an output valid.

Function
REQ-022 SHALL hold one registered slot per source; ready = slot empty (registered, not a function of the grant); accept on valid&&ready, capture the payload that cycle.
REQ-023 SHALL grant at most one occupied slot per cycle; fixed priority TLP>USB>INT.
REQ-024 SHALL keep a 4-bit saturating wait counter per slot: increment each cycle the slot is occupied and not granted, clear on grant.
REQ-025 SHALL give a slot whose counter >= STARVE_MAX precedence over non-starved slots; ties among starved slots resolve TLP>USB>INT.
REQ-026 SHALL register the granted op onto the bram_* outputs in the cycle after the grant, valid for exactly 1 cycle; the slot frees that same edge (ready=1 the next cycle).
REQ-027 SHALL drive the bram_* outputs to all zeros (bram_tp=00) on cycles with no issue.
REQ-028 Field mapping: TLP -> tag=tag, reqid=reqid, tlpwr=wr, be = wr&tlp_wren_en ? be : 0; USB -> tag={7'h0,addr_lo}, reqid=0, tlpwr=0, be = wr ? be : 0; INT -> tag=0, reqid=0, tlpwr=0, be = wr ? be : 0; data passes through unchanged.
REQ-029 Hazard rule: if the op issued in cycle t has bram_be!=0 and the winning candidate in cycle t has the same addr, SHALL issue idle in cycle t+1 and grant that candidate one cycle later; wait counters keep counting during the bubble.
REQ-030 SHALL give a TLP op issued during the hazard bubble no completion; it issues after the bubble with tp=01.
REQ-031 Simultaneous accept and grant on different slots SHALL both take effect; no request is ever dropped.
REQ-032 Latency from accept (cycle t) to issue SHALL be >= 2 cycles (t+2 when uncontested and hazard-free).
REQ-033 busy = OR of slot-occupied flags and (bram_tp!=00).

Reset
REQ-034 While rst_n=0 (asynchronously), SHALL clear all slots and counters, set bram_*=0, busy=0, and *_ready=0.
REQ-035 SHALL set *_ready=1 on the first clock edge after rst_n deasserts.
REQ-036 An in-flight op SHALL be discarded by reset and not reissued.

Verification
REQ-037 Single TLP read addr=0x004, tag=0x12, reqid=0xBEEF accepted at cycle t -> cycle t+2: bram_tp=01, addr=0x004, be=0, tag=0x12, reqid=0xBEEF, tlpwr=0.
REQ-038 TLP, USB and INT all accepted in the same cycle -> issue order TLP, USB, INT on consecutive cycles; busy=0 after the last issue.
REQ-039 TLP write be=0xF to addr=0x010, immediately followed by a USB read of 0x010 -> one idle cycle between the issues; USB issues with tag=0 or 1 per addr_lo.
REQ-040 TLP write with tlp_wren_en=0 -> issue with be=0, tlpwr=1, tp=01.
REQ-041 TLP source re-valid every cycle, INT pending, STARVE_MAX=8 -> INT issues no later than 9 cycles after its accept.
REQ-042 rst_n pulsed low mid-stream with all slots full -> outputs zero immediately; after release no stale op issues and ready=1.

Source files
------------

// File: rtl/pcileech_cfgspace_arbiter.sv
// Three-source config-space arbiter: one holding slot per source (TLP/USB/INT),
// fixed priority with starvation override, write-after-write/read address hazard bubble.
package pcileech_cfgspace_pkg;
  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [15:0] reqid;
    logic        tlpwr;
  } op_t;
endpackage

module pcileech_cfgspace_slot
  import pcileech_cfgspace_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       acc_i,
  input  logic       gnt_i,
  input  op_t        op_i,
  output logic       occ_o,
  output logic [3:0] cnt_o,
  output op_t        op_o
);
  logic       occ_q, occ_d;
  logic [3:0] cnt_q, cnt_d;
  op_t        op_q, op_d;

  // acc and gnt are never both set: a slot only accepts while empty.
  always_comb begin
    occ_d = occ_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (acc_i) begin
      occ_d = 1'b1;
      op_d  = op_i;
    end else if (gnt_i) begin
      occ_d = 1'b0;
    end
    if (gnt_i)                        cnt_d = 4'h0;
    else if (occ_q && cnt_q != 4'hF)  cnt_d = cnt_q + 4'h1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= 1'b0;
      cnt_q <= 4'h0;
      op_q  <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  assign occ_o = occ_q;
  assign cnt_o = cnt_q;
  assign op_o  = op_q;
endmodule

module pcileech_cfgspace_arbiter
  import pcileech_cfgspace_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk_pcie,
  input  logic        rst_n,
  input  logic        tlp_valid,
  output logic        tlp_ready,
  input  logic [70:0] tlp_req,
  input  logic        tlp_wren_en,
  input  logic        usb_valid,
  output logic        usb_ready,
  input  logic [47:0] usb_req,
  input  logic        int_valid,
  output logic        int_ready,
  input  logic [46:0] int_req,
  output logic [9:0]  bram_addr,
  output logic [3:0]  bram_be,
  output logic [31:0] bram_data,
  output logic [7:0]  bram_tag,
  output logic [1:0]  bram_tp,
  output logic [15:0] bram_reqid,
  output logic        bram_tlpwr,
  output logic        busy
);
  localparam int NSRC = 3;

  logic [NSRC-1:0]      vld, acc, gnt, occ, starved, cand;
  logic [NSRC-1:0][3:0] cnt;
  op_t  [NSRC-1:0]      in_op, slot_op;
  logic                 rdy_en_q;
  logic                 win_vld, hazard;
  logic [1:0]           win_idx;
  op_t                  out_q, out_d;
  logic [1:0]           tp_q, tp_d;

  // Normalise each source into a common op; write masking is applied at capture.
  always_comb begin
    in_op[0].addr  = tlp_req[69:60];
    in_op[0].be    = (tlp_req[70] && tlp_wren_en) ? tlp_req[59:56] : 4'h0;
    in_op[0].data  = tlp_req[55:24];
    in_op[0].tag   = tlp_req[23:16];
    in_op[0].reqid = tlp_req[15:0];
    in_op[0].tlpwr = tlp_req[70];
    in_op[1].addr  = usb_req[45:36];
    in_op[1].be    = usb_req[47] ? usb_req[35:32] : 4'h0;
    in_op[1].data  = usb_req[31:0];
    in_op[1].tag   = {7'h0, usb_req[46]};
    in_op[1].reqid = 16'h0;
    in_op[1].tlpwr = 1'b0;
    in_op[2].addr  = int_req[45:36];
    in_op[2].be    = int_req[46] ? int_req[35:32] : 4'h0;
    in_op[2].data  = int_req[31:0];
    in_op[2].tag   = 8'h0;
    in_op[2].reqid = 16'h0;
    in_op[2].tlpwr = 1'b0;
  end

  assign vld = {int_valid, usb_valid, tlp_valid};
  assign acc = vld & ~occ & {NSRC{rdy_en_q}};

  for (genvar i = 0; i < NSRC; i++) begin : g_slot
    pcileech_cfgspace_slot u_slot (
      .clk_i  (clk_pcie),
      .rst_ni (rst_n),
      .acc_i  (acc[i]),
      .gnt_i  (gnt[i]),
      .op_i   (in_op[i]),
      .occ_o  (occ[i]),
      .cnt_o  (cnt[i]),
      .op_o   (slot_op[i])
    );
  end

  // Starved slots pre-empt the plain priority order; index 0 is always highest.
  always_comb begin
    for (int i = 0; i < NSRC; i++)
      starved[i] = occ[i] && (cnt[i] >= 4'(STARVE_MAX));
    cand    = (|starved) ? starved : occ;
    win_vld = |cand;
    win_idx = 2'd0;
    if (cand[0])      win_idx = 2'd0;
    else if (cand[1]) win_idx = 2'd1;
    else if (cand[2]) win_idx = 2'd2;
    hazard = win_vld && (out_q.be != 4'h0) && (slot_op[win_idx].addr == out_q.addr);
    gnt    = (win_vld && !hazard) ? (NSRC'(1) << win_idx) : '0;
    out_d  = (win_vld && !hazard) ? slot_op[win_idx] : '0;
    tp_d   = (win_vld && !hazard) ? win_idx + 2'd1 : 2'd0;
  end

  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      out_q    <= '0;
      tp_q     <= 2'd0;
    end else begin
      rdy_en_q <= 1'b1;
      out_q    <= out_d;
      tp_q     <= tp_d;
    end
  end

  assign tlp_ready  = rdy_en_q & ~occ[0];
  assign usb_ready  = rdy_en_q & ~occ[1];
  assign int_ready  = rdy_en_q & ~occ[2];
  assign bram_addr  = out_q.addr;
  assign bram_be    = out_q.be;
  assign bram_data  = out_q.data;
  assign bram_tag   = out_q.tag;
  assign bram_reqid = out_q.reqid;
  assign bram_tlpwr = out_q.tlpwr;
  assign bram_tp    = tp_q;
  assign busy       = (|occ) | (tp_q != 2'd0);
endmodule
